// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arbiter
//  Description : Single-port VRAM arbiter between a video fetch stream and a
//                one-entry CPU access port. Video reads and CPU reads in flight
//                are tracked by a 2-stage tag pipeline that routes each returned
//                byte to one destination.
//                Optional macro VRAM_ARB_STARVE_EN: enables the CPU starvation
//                counter (CPU forced after STARVE_MAX denied cycles). Without it
//                video has strict priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_valid,
  output logic [7:0]  vid_data,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_ovf,
  output logic [13:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  localparam logic [1:0] c_TAG_NONE = 2'd0;
  localparam logic [1:0] c_TAG_VID  = 2'd1;
  localparam logic [1:0] c_TAG_CPU  = 2'd2;

  // One-entry CPU pending register
  logic        r_pend_vld;
  logic        r_pend_we;
  logic [13:0] r_pend_addr;
  logic [7:0]  r_pend_data;

  // Read-return tag pipeline: stage 1 = address on the bus, stage 2 = data on mem_dout
  logic [1:0]  r_tag1;
  logic [1:0]  r_tag2;

  // Registered outputs
  logic        r_vid_ack;
  logic        r_vid_valid;
  logic [7:0]  r_vid_data;
  logic [7:0]  r_cpu_dout;
  logic        r_cpu_done;
  logic        r_cpu_ovf;
  logic [13:0] r_mem_addr;
  logic        r_mem_we;
  logic [7:0]  r_mem_din;

  logic        w_strobe;
  logic        w_cpu_busy;
  logic        w_force;
  logic        w_vid_gnt;
  logic        w_cpu_gnt;

  assign w_strobe   = cpu_wr | cpu_rd;
  // A CPU read stays busy until its data returns; a write frees the port the
  // cycle it is on the bus.
  assign w_cpu_busy = r_pend_vld | (r_tag1 == c_TAG_CPU) | (r_tag2 == c_TAG_CPU);
  assign w_vid_gnt  = vid_req & ~w_force;
  assign w_cpu_gnt  = r_pend_vld & ~w_vid_gnt;

`ifdef VRAM_ARB_STARVE_EN
  localparam int c_CNT_W = $clog2(STARVE_MAX + 1);
  logic [c_CNT_W-1:0] r_starve;

  // Count cycles a pending CPU access is denied; saturates at STARVE_MAX
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (w_cpu_gnt) begin
      r_starve <= '0;
    end else if (r_pend_vld && (r_starve != c_CNT_W'(STARVE_MAX))) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign w_force = r_pend_vld & (r_starve == c_CNT_W'(STARVE_MAX));
`else
  assign w_force = 1'b0;
`endif

  // Capture CPU strobes into the pending register; release it on grant
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_we   <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else if (w_cpu_gnt) begin
      r_pend_vld  <= 1'b0;
    end else if (w_strobe && !w_cpu_busy) begin
      // Write wins when both strobes arrive together
      r_pend_vld  <= 1'b1;
      r_pend_we   <= cpu_wr;
      r_pend_addr <= cpu_addr;
      r_pend_data <= cpu_din;
    end
  end

  // Drive the VRAM bus with the granted access and advance the tag pipeline
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      r_mem_din  <= '0;
      r_vid_ack  <= 1'b0;
      r_tag1     <= c_TAG_NONE;
      r_tag2     <= c_TAG_NONE;
    end else begin
      r_mem_we  <= 1'b0;
      r_vid_ack <= w_vid_gnt;
      r_tag1    <= c_TAG_NONE;
      r_tag2    <= r_tag1;
      if (w_vid_gnt) begin
        r_mem_addr <= vid_addr;
        r_tag1     <= c_TAG_VID;
      end else if (w_cpu_gnt) begin
        r_mem_addr <= r_pend_addr;
        if (r_pend_we) begin
          r_mem_we  <= 1'b1;
          r_mem_din <= r_pend_data;
        end else begin
          r_tag1    <= c_TAG_CPU;
        end
      end
    end
  end

  // Route returned read data and generate completion/overflow pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
      r_cpu_dout  <= '0;
      r_cpu_done  <= 1'b0;
      r_cpu_ovf   <= 1'b0;
    end else begin
      r_vid_valid <= (r_tag2 == c_TAG_VID);
      r_cpu_done  <= (w_cpu_gnt & r_pend_we) | (r_tag2 == c_TAG_CPU);
      r_cpu_ovf   <= w_strobe & w_cpu_busy;
      if (r_tag2 == c_TAG_VID) begin
        r_vid_data <= mem_dout;
      end
      if (r_tag2 == c_TAG_CPU) begin
        r_cpu_dout <= mem_dout;
      end
    end
  end

  assign vid_ack   = r_vid_ack;
  assign vid_valid = r_vid_valid;
  assign vid_data  = r_vid_data;
  assign cpu_dout  = r_cpu_dout;
  assign cpu_busy  = w_cpu_busy;
  assign cpu_done  = r_cpu_done;
  assign cpu_ovf   = r_cpu_ovf;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_din   = r_mem_din;

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 8: maximum number of cycles a pending CPU access waits while video holds priority.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, the system/VGA clock; every port is synchronous to it.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port vid_req, input, 1 bit: video fetch request (level).
REQ-005 The block SHALL have port vid_addr, input, 14 bits: video fetch address.
REQ-006 The block SHALL have port vid_ack, output, 1 bit: one-cycle grant pulse; the video requester presents its next address afterwards.
REQ-007 The block SHALL have port vid_valid, output, 1 bit: one-cycle pulse marking vid_data valid.
REQ-008 The block SHALL have port vid_data, output, 8 bits: video read data.
REQ-009 The block SHALL have port cpu_wr, input, 1 bit: one-cycle CPU write strobe.
REQ-010 The block SHALL have port cpu_rd, input, 1 bit: one-cycle CPU read strobe.
REQ-011 The block SHALL have port cpu_addr, input, 14 bits: CPU address, sampled with the strobe.
REQ-012 The block SHALL have port cpu_din, input, 8 bits: CPU write data, sampled with the strobe.
REQ-013 The block SHALL have port cpu_dout, output, 8 bits: CPU read data.
REQ-014 The block SHALL have port cpu_busy, output, 1 bit: a CPU access is pending or in flight.
REQ-015 The block SHALL have port cpu_done, output, 1 bit: one-cycle completion pulse.
REQ-016 The block SHALL have port cpu_ovf, output, 1 bit: one-cycle pulse when a strobe is dropped.
REQ-017 The block SHALL have port mem_addr, output, 14 bits: registered VRAM address.
REQ-018 The block SHALL have port mem_we, output, 1 bit: registered VRAM write enable.
REQ-019 The block SHALL have port mem_din, output, 8 bits: registered VRAM write data.
REQ-020 The block SHALL have port mem_dout, input, 8 bits: data from synchronous single-port VRAM, valid one edge after the address.

Function
REQ-021 Per clock edge the block SHALL issue at most one VRAM access, chosen in this order:
- forced CPU slot (REQ-025);
- video (vid_req=1);
- pending CPU access;
- idle (mem_we=0).
REQ-022 A video grant at edge E SHALL have these effects:
- mem_addr<=vid_addr, mem_we<=0, vid_ack=1 for the following cycle;
- vid_data<=mem_dout with vid_valid=1 at edge E+2;
- back-to-back grants SHALL sustain one access per cycle.
REQ-023 A cpu_wr or cpu_rd strobe seen while not busy SHALL be captured into a one-entry pending register (address, data, type), with cpu_busy=1 from the next cycle; the earliest grant is the edge after capture.
REQ-024 A strobe seen while cpu_busy=1 SHALL be dropped and SHALL pulse cpu_ovf; when cpu_wr and cpu_rd are both high, the write SHALL be taken and the read dropped without cpu_ovf.
REQ-025 A starvation counter SHALL count cycles in which a CPU access is pending but not granted; when it reaches STARVE_MAX, the CPU SHALL win the next edge even if vid_req=1; the counter SHALL clear on any CPU grant.
REQ-026 A CPU write granted at edge E SHALL drive mem_addr, mem_din, mem_we<=1 for one cycle; cpu_done SHALL pulse in that same cycle.
REQ-027 A CPU read granted at edge E SHALL drive mem_we<=0; at edge E+2 cpu_dout<=mem_dout and cpu_done pulses.
REQ-028 cpu_busy SHALL fall in the cycle in which cpu_done=1, and a strobe in that cycle SHALL be accepted.
REQ-029 Video and CPU reads in flight SHALL be tracked by a 2-stage tag pipeline so that each returned byte is routed to exactly one destination.
REQ-030 Addresses SHALL be used as given (14 bits), with no wrap or increment logic inside this block.

Reset
REQ-031 While reset_n=0 at an edge, all outputs SHALL go to 0, including vid_data, cpu_dout, mem_addr and mem_din.
REQ-032 Reset SHALL clear the pending register, the starvation counter and the tag pipeline.
REQ-033 Accesses in flight when reset asserts SHALL be discarded, producing no vid_valid or cpu_done.

Configuration
REQ-034 With VRAM_ARB_STARVE_EN defined, REQ-025 SHALL apply.
REQ-035 Without VRAM_ARB_STARVE_EN, video SHALL have strict priority: the counter SHALL be absent, and a CPU access SHALL wait as long as vid_req=1.

Verification
REQ-036 The bench SHALL cover a video stream: vid_req held high with addr 0x0000..0x0003 (VRAM preloaded addr=data) -> four consecutive vid_ack, then vid_valid with data 0x00..0x03 two cycles after each ack.
REQ-037 The bench SHALL cover an idle-bus write then read: cpu_wr addr 0x1234 data 0xA5 then cpu_rd 0x1234 with vid_req=0 -> write cpu_done one cycle after capture; read cpu_done with cpu_dout=0xA5 three cycles after the read strobe.
REQ-038 The bench SHALL cover starvation with the macro defined: vid_req high continuously, cpu_rd at cycle 0 -> CPU slot granted after exactly 8 denied cycles, and one vid_ack missing in that cycle.
REQ-039 The bench SHALL cover strict priority without the macro: the same stimulus gives no CPU grant until vid_req drops, then a grant on the next edge.
REQ-040 The bench SHALL cover overrun: cpu_wr while cpu_busy=1 -> cpu_ovf pulse, and VRAM unchanged at that address.
REQ-041 The bench SHALL cover reset mid-read: reset_n low one cycle after a CPU read grant -> no cpu_done, all outputs 0, cpu_busy=0.
